// File: rtl/sram_req_ctrl_if.sv
// Client request/response bundle and SRAM macro bundle for sram_req_ctrl.
// master drives requests (client) or the SRAM access (controller); slave is the other side.
interface sram_req_ctrl_if #(
    parameter int AW = 9,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

interface sram_mem_if #(
    parameter int AW = 9,
    parameter int DW = 32
);
    logic          mem_en;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_en, mem_wen, mem_addr, mem_wdata,
        input  mem_rdata
    );
    modport slave (
        input  mem_en, mem_wen, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/sram_req_ctrl.sv
// Valid/ready front-end for a single-port SRAM with a 2-entry FWFT read-response buffer.
// Define SRAM_REQ_CTRL_CLEAR_EN to write CLEAR_VALUE to the whole array after reset.
//
// state    | meaning
// ST_CLEAR | sweeping every address with CLEAR_VALUE, requests held off
// ST_RUN   | serving client requests, one SRAM access per cycle
module sram_req_ctrl #(
    parameter int            AW          = 9,
    parameter int            DW          = 32,
    parameter logic [DW-1:0] CLEAR_VALUE = '0
) (
    input  logic           clk,
    input  logic           reset_n,
    sram_req_ctrl_if.slave cli,
    sram_mem_if.master     mem,
    output logic           init_done
);
    logic          live;
    logic          run;
    logic          clearing;
    logic          rd_room;
    logic          acc;
    logic          rd_acc;
    logic          inflight;
    logic [1:0]    fifo_cnt;
    logic          rd_ptr;
    logic          wr_ptr;
    logic [DW-1:0] fifo_mem [2];
    logic          push;
    logic          pop;
    logic          store;
    logic          take;
    logic          wen_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    // Handshake and SRAM strobe stay quiet while reset is held.
    assign live = reset_n;

`ifdef SRAM_REQ_CTRL_CLEAR_EN
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] clr_cnt;
    logic [AW-1:0] clr_cnt_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            ST_CLEAR: begin
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == {AW{1'b1}}) state_nxt = ST_RUN;
            end
            default: ;
        endcase
    end

    assign run       = live & (state == ST_RUN);
    assign clearing  = live & (state == ST_CLEAR);
    assign init_done = (state == ST_RUN);
`else
    // Clear value only matters when the sweep is built in.
    logic [DW-1:0] unused_clear_value;
    assign unused_clear_value = CLEAR_VALUE;
    assign run       = live;
    assign clearing  = 1'b0;
    assign init_done = 1'b1;
`endif

    // A read is only taken when its response slot is already reserved.
    assign rd_room       = ({1'b0, fifo_cnt} + {2'b00, inflight}) < 3'd2;
    assign cli.req_ready = run & (cli.req_write | rd_room);
    assign acc           = cli.req_valid & cli.req_ready;
    assign rd_acc        = acc & ~cli.req_write;

    always_comb begin
        mem.mem_en    = 1'b0;
        mem.mem_wen   = wen_q;
        mem.mem_addr  = addr_q;
        mem.mem_wdata = wdata_q;
`ifdef SRAM_REQ_CTRL_CLEAR_EN
        if (clearing) begin
            mem.mem_en    = 1'b1;
            mem.mem_wen   = 1'b1;
            mem.mem_addr  = clr_cnt;
            mem.mem_wdata = CLEAR_VALUE;
        end else
`endif
        if (acc) begin
            mem.mem_en    = 1'b1;
            mem.mem_wen   = cli.req_write;
            mem.mem_addr  = cli.req_addr;
            mem.mem_wdata = cli.req_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (mem.mem_en) begin
            wen_q   <= mem.mem_wen;
            addr_q  <= mem.mem_addr;
            wdata_q <= mem.mem_wdata;
        end
    end

    // Returning read data bypasses storage when the buffer is empty and the client takes it.
    assign cli.rsp_valid = (fifo_cnt != 2'd0) | inflight;
    assign cli.rsp_rdata = (fifo_cnt != 2'd0) ? fifo_mem[rd_ptr] :
                           (inflight ? mem.mem_rdata : '0);
    assign push  = inflight;
    assign pop   = cli.rsp_valid & cli.rsp_ready;
    assign store = push & ~((fifo_cnt == 2'd0) & pop);
    assign take  = pop & (fifo_cnt != 2'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight    <= 1'b0;
            fifo_cnt    <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            inflight <= rd_acc;
            if (store) begin
                fifo_mem[wr_ptr] <= mem.mem_rdata;
                wr_ptr           <= ~wr_ptr;
            end
            if (take) rd_ptr <= ~rd_ptr;
            case ({store, take})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed self-checking bench for sram_req_ctrl with a behavioural 512x32 SRAM.
// Expectations follow SRAM_REQ_CTRL_CLEAR_EN when it is defined for the whole build.
module tb_sram_req_ctrl;
    localparam int AW = 9;
    localparam int DW = 32;

    logic clk;
    logic reset_n;
    logic init_done;
    int   checks;
    int   failures;
    logic [DW-1:0] sram [2**AW];

    sram_req_ctrl_if #(.AW(AW), .DW(DW)) cli ();
    sram_mem_if      #(.AW(AW), .DW(DW)) mem ();

    sram_req_ctrl #(.AW(AW), .DW(DW), .CLEAR_VALUE(32'h0)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cli       (cli),
        .mem       (mem),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem.mem_en) begin
            if (mem.mem_wen) sram[mem.mem_addr] <= mem.mem_wdata;
            else             mem.mem_rdata      <= sram[mem.mem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        cli.req_valid = v;
        cli.req_write = w;
        cli.req_addr  = a;
        cli.req_wdata = d;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] dpat(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h111;
    endfunction

    task automatic read_back(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        drive(1'b1, 1'b0, a, '0);
        @(negedge clk);
        chk({tag, "_ready"}, 64'(cli.req_ready), 64'd1);
        next_cycle();
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk({tag, "_rsp_valid"}, 64'(cli.rsp_valid), 64'd1);
        chk({tag, "_rsp_rdata"}, 64'(cli.rsp_rdata), 64'(exp));
        next_cycle();
    endtask

    initial begin
        int bad;
        int n;
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        cli.rsp_ready = 1'b1;
        drive(1'b0, 1'b0, '0, '0);

        // Reset values
        #2;
        chk("rst_req_ready", 64'(cli.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(cli.rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(cli.rsp_rdata), 64'd0);
        chk("rst_mem_en",    64'(mem.mem_en),    64'd0);
        chk("rst_mem_wen",   64'(mem.mem_wen),   64'd0);
        chk("rst_mem_addr",  64'(mem.mem_addr),  64'd0);
        chk("rst_mem_wdata", 64'(mem.mem_wdata), 64'd0);
`ifdef SRAM_REQ_CTRL_CLEAR_EN
        chk("rst_init_done", 64'(init_done), 64'd0);
`else
        chk("rst_init_done", 64'(init_done), 64'd1);
`endif
        @(posedge clk); @(posedge clk); @(posedge clk);
        #1;
        reset_n = 1'b1;
        // A write presented right away must be held off, not dropped.
        drive(1'b1, 1'b1, 9'd5, 32'h5555_5555);

`ifdef SRAM_REQ_CTRL_CLEAR_EN
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (mem.mem_en !== 1'b1 || mem.mem_wen !== 1'b1 || mem.mem_addr !== 9'(i) ||
                mem.mem_wdata !== 32'h0 || cli.req_ready !== 1'b0 || init_done !== 1'b0)
                bad++;
        end
        chk("clear_bad_cycles", 64'(bad), 64'd0);
        @(negedge clk);
`else
        @(negedge clk);
`endif
        chk("init_done_high",  64'(init_done),     64'd1);
        chk("held_wr_ready",   64'(cli.req_ready), 64'd1);
        chk("held_wr_mem_en",  64'(mem.mem_en),    64'd1);
        chk("held_wr_mem_wen", 64'(mem.mem_wen),   64'd1);
        chk("held_wr_addr",    64'(mem.mem_addr),  64'd5);
        next_cycle();
        read_back("held_wr_read", 9'd5, 32'h5555_5555);
`ifdef SRAM_REQ_CTRL_CLEAR_EN
        read_back("cleared_read", 9'd300, 32'h0);
`endif

        // Write then read the same address on the next cycle
        drive(1'b1, 1'b1, 9'h1A5, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("wr_ready", 64'(cli.req_ready), 64'd1);
        chk("wr_mem_en", 64'(mem.mem_en), 64'd1);
        chk("wr_mem_wen", 64'(mem.mem_wen), 64'd1);
        chk("wr_mem_addr", 64'(mem.mem_addr), 64'h1A5);
        chk("wr_mem_wdata", 64'(mem.mem_wdata), 64'hDEAD_BEEF);
        next_cycle();
        drive(1'b1, 1'b0, 9'h1A5, '0);
        @(negedge clk);
        chk("rd_ready", 64'(cli.req_ready), 64'd1);
        chk("rd_mem_wen", 64'(mem.mem_wen), 64'd0);
        chk("rd_rsp_valid_early", 64'(cli.rsp_valid), 64'd0);
        next_cycle();
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("rd_rsp_valid", 64'(cli.rsp_valid), 64'd1);
        chk("rd_rsp_rdata", 64'(cli.rsp_rdata), 64'hDEAD_BEEF);
        chk("idle_mem_en", 64'(mem.mem_en), 64'd0);
        chk("idle_addr_hold", 64'(mem.mem_addr), 64'h1A5);
        next_cycle();
        @(negedge clk);
        chk("rd_rsp_drained", 64'(cli.rsp_valid), 64'd0);
        next_cycle();

        // Fill 0..15 with distinct data
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 9'(i), dpat(i));
            @(negedge clk);
            chk("fill_ready", 64'(cli.req_ready), 64'd1);
            next_cycle();
        end

        // Streaming reads: one accept per cycle, responses without bubbles
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 9'(i), '0);
            @(negedge clk);
            chk("stream_ready", 64'(cli.req_ready), 64'd1);
            if (i > 0) begin
                chk("stream_rsp_valid", 64'(cli.rsp_valid), 64'd1);
                chk("stream_rsp_rdata", 64'(cli.rsp_rdata), 64'(dpat(i - 1)));
            end
            next_cycle();
        end
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("stream_last_rdata", 64'(cli.rsp_rdata), 64'(dpat(15)));
        next_cycle();
        @(negedge clk);
        chk("stream_drained", 64'(cli.rsp_valid), 64'd0);
        next_cycle();

        // Backpressure: only two reads fit while the client stalls
        cli.rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 9'd0, '0);
        @(negedge clk);
        chk("bp_acc0", 64'(cli.req_ready), 64'd1);
        next_cycle();
        drive(1'b1, 1'b0, 9'd1, '0);
        @(negedge clk);
        chk("bp_acc1", 64'(cli.req_ready), 64'd1);
        chk("bp_rsp0_valid", 64'(cli.rsp_valid), 64'd1);
        chk("bp_rsp0_rdata", 64'(cli.rsp_rdata), 64'(dpat(0)));
        next_cycle();
        drive(1'b1, 1'b0, 9'd2, '0);
        @(negedge clk);
        chk("bp_block_a", 64'(cli.req_ready), 64'd0);
        next_cycle();
        @(negedge clk);
        chk("bp_block_b", 64'(cli.req_ready), 64'd0);
        chk("bp_head_hold", 64'(cli.rsp_rdata), 64'(dpat(0)));
        next_cycle();
        cli.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_full_ready", 64'(cli.req_ready), 64'd0);
        chk("bp_pop0", 64'(cli.rsp_rdata), 64'(dpat(0)));
        next_cycle();
        @(negedge clk);
        chk("bp_acc2", 64'(cli.req_ready), 64'd1);
        chk("bp_pop1", 64'(cli.rsp_rdata), 64'(dpat(1)));
        next_cycle();
        drive(1'b1, 1'b0, 9'd3, '0);
        @(negedge clk);
        chk("bp_acc3", 64'(cli.req_ready), 64'd1);
        chk("bp_pop2", 64'(cli.rsp_rdata), 64'(dpat(2)));
        next_cycle();
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("bp_pop3_valid", 64'(cli.rsp_valid), 64'd1);
        chk("bp_pop3", 64'(cli.rsp_rdata), 64'(dpat(3)));
        next_cycle();
        @(negedge clk);
        chk("bp_drained", 64'(cli.rsp_valid), 64'd0);
        next_cycle();

        // Mixed ordering W(3,A) R(3) W(3,B) R(3)
        drive(1'b1, 1'b1, 9'd3, 32'h1111_AAAA);
        @(negedge clk);
        chk("mix_w1_ready", 64'(cli.req_ready), 64'd1);
        next_cycle();
        drive(1'b1, 1'b0, 9'd3, '0);
        @(negedge clk);
        chk("mix_r1_ready", 64'(cli.req_ready), 64'd1);
        next_cycle();
        drive(1'b1, 1'b1, 9'd3, 32'h2222_BBBB);
        @(negedge clk);
        chk("mix_w2_ready", 64'(cli.req_ready), 64'd1);
        chk("mix_rsp_a_valid", 64'(cli.rsp_valid), 64'd1);
        chk("mix_rsp_a", 64'(cli.rsp_rdata), 64'h1111_AAAA);
        next_cycle();
        drive(1'b1, 1'b0, 9'd3, '0);
        @(negedge clk);
        chk("mix_r2_ready", 64'(cli.req_ready), 64'd1);
        chk("mix_gap", 64'(cli.rsp_valid), 64'd0);
        next_cycle();
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("mix_rsp_b_valid", 64'(cli.rsp_valid), 64'd1);
        chk("mix_rsp_b", 64'(cli.rsp_rdata), 64'h2222_BBBB);
        next_cycle();

        // Reset with two responses buffered
        cli.rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 9'd0, '0);
        next_cycle();
        drive(1'b1, 1'b0, 9'd1, '0);
        next_cycle();
        drive(1'b0, 1'b0, '0, '0);
        next_cycle();
        @(negedge clk);
        chk("mr_buffered_valid", 64'(cli.rsp_valid), 64'd1);
        chk("mr_buffered_head", 64'(cli.rsp_rdata), 64'(dpat(0)));
        chk("mr_full_ready", 64'(cli.req_ready), 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_rsp_valid", 64'(cli.rsp_valid), 64'd0);
        chk("mr_rsp_rdata", 64'(cli.rsp_rdata), 64'd0);
        chk("mr_mem_en", 64'(mem.mem_en), 64'd0);
        cli.rsp_ready = 1'b1;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        bad = 0;
        n   = 0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            n = i;
            if (cli.rsp_valid !== 1'b0) bad++;
`ifdef SRAM_REQ_CTRL_CLEAR_EN
            if (i == 1) chk("mr_clear_addr0", 64'(mem.mem_addr), 64'd0);
            if (i == 2) chk("mr_clear_addr1", 64'(mem.mem_addr), 64'd1);
`endif
            if (init_done === 1'b1 && i >= 4) break;
        end
        chk("mr_stale_rsp", 64'(bad), 64'd0);
`ifdef SRAM_REQ_CTRL_CLEAR_EN
        chk("mr_init_cycles", 64'(n), 64'd513);
`else
        chk("mr_init_cycles", 64'(n), 64'd4);
`endif
        chk("mr_init_done", 64'(init_done), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_req_ctrl.md
Name: sram_req_ctrl

Overview:
- Initiator-side controller for the 512x32 single-port SRAM wrapper port (en/addr/wen/wdata/rdata).
- Accepts valid/ready read and write requests from a core-side client, drives one SRAM access per cycle, and returns read data through a 2-entry response buffer with backpressure.
- Optionally clears the whole array after reset before accepting traffic.
- Sits between bus/CPU glue logic and the SRAM macro wrapper.

Parameters:
- AW, 9, address width; depth = 2**AW words.
- DW, 32, data width.
- CLEAR_VALUE, 32'h0, word written to every location by the clear sequencer.

Ports:
- clk  in  1  single clock; all state on posedge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&ready at posedge.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  AW  word address.
- req_wdata  in  DW  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  client consumes response when valid&ready.
- rsp_rdata  out  DW  read data.
- init_done  out  1  high once the array is ready for traffic.
- mem_en  out  1  SRAM access strobe (one access per cycle while high).
- mem_wen  out  1  SRAM write enable (1 = write).
- mem_addr  out  AW  SRAM address.
- mem_wdata  out  DW  SRAM write data.
- mem_rdata  in  DW  SRAM read data; valid the cycle after a read access (mem_en=1, mem_wen=0) is sampled.

Behaviour:
- Reset (async assert, sync release): state=CLEAR (or RUN without the macro); clear counter=0; response FIFO empty; read-inflight flag=0.
- Output reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0 (1 without the macro), mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0.
- mem_* outputs are combinational from the accepted request (or clear counter). An access is issued in the same cycle req_valid&req_ready is high; there is no request-side registering.
- State CLEAR:
  - mem_en=1, mem_wen=1, mem_addr=counter, mem_wdata=CLEAR_VALUE, req_ready=0.
  - Counter increments each cycle.
  - When the access at counter = 2**AW-1 completes: go to RUN and set init_done=1 the following cycle.
  - Requests presented during CLEAR are held off, not dropped.
- State RUN:
  - Writes: req_ready=1 unconditionally. A write produces no response and completes in the acceptance cycle.
  - Reads: req_ready = (fifo_count + inflight) < 2, which guarantees the response slot is reserved.
  - Accepted read: sets inflight. The next cycle, mem_rdata is pushed into the FIFO and inflight clears.
  - Read latency: req accept at cycle N, rsp_valid at cycle N+1 if the FIFO was empty. Back-to-back reads sustain 1/cycle while rsp_ready=1.
- Response FIFO:
  - 2 entries, first-word-fall-through. rsp_rdata = head entry.
  - Push and pop in the same cycle keep the count unchanged.
  - Count never exceeds 2; the ready rule prevents overflow, and an overflow is a verification error.
- Ordering:
  - Requests execute strictly in acceptance order.
  - A read of an address written the previous cycle returns the new data.
  - Responses return in request order.
- When no request is accepted, mem_en=0 and the other mem_* values are don't-care (hold them at the last value for low toggling).
- reset_n asserted mid-operation:
  - Inflight reads and FIFO contents are discarded; no rsp_valid is seen after reset.
  - The clear sequence restarts from address 0.

Optional Feature:
- Macro: SRAM_REQ_CTRL_CLEAR_EN.
- Defined: the CLEAR state and clear counter are present. init_done rises 2**AW+1 cycles after reset release (513 for AW=9), and all words read CLEAR_VALUE before any write.
- Undefined: no counter, reset goes directly to RUN, init_done is tied to 1, and SRAM contents are undefined until written.

Test Plan:
- Clear (macro on, AW=9): release reset -> exactly 512 consecutive cycles of mem_en=1, mem_wen=1, addresses 0..511, data 0. init_done=1 at cycle 513. req_ready=0 throughout.
- Write then read: write addr 9'h1A5 data 32'hDEADBEEF, then read 9'h1A5 on the next cycle -> rsp_valid one cycle after the read is accepted, rsp_rdata=32'hDEADBEEF.
- Backpressure: rsp_ready=0, issue 4 back-to-back reads -> exactly 2 accepted, req_ready=0 afterwards. Raise rsp_ready -> both responses return in order, then the remaining reads are accepted.
- Streaming: rsp_ready=1, 16 consecutive reads of addresses 0..15 -> one accept per cycle, 16 responses in order with no bubbles.
- Mixed ordering: sequence W(3,A), R(3), W(3,B), R(3) -> responses A then B.
- Reset mid-read: assert reset_n low with 2 responses buffered -> rsp_valid=0 immediately. After release, the clear restarts at address 0 and no stale response appears.
